// File: rtl/ej32_pkg.sv
`default_nettype none
//==============================================================================
// ej32_pkg : shared fetch-unit types and constants for the eJ32 core
// Revision : 1.0
//==============================================================================
package ej32_pkg;

  localparam int EJ32_AW = 17;
  localparam logic [EJ32_AW-1:0] EJ32_RESET_VEC = '0;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_FETCH = 2'd1,
    F_DRAIN = 2'd2
  } fetch_st_t;

endpackage
`default_nettype wire

// File: rtl/ej32_fetch_if.sv
`default_nettype none
//==============================================================================
// ej32_fetch_if : byte-wide fetch read port on the shared memory bus
// Revision      : 1.0
//==============================================================================
interface ej32_fetch_if #(
  parameter int AW = ej32_pkg::EJ32_AW
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/ej32_pfq.sv
`default_nettype none
//==============================================================================
// ej32_pfq : DEPTH x 8 prefetch queue with push, pop, flush and registered head
// Revision : 1.0
//==============================================================================
module ej32_pfq
  import ej32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head,
  output logic                   head_vld
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push && (cnt_q != FULL);
    do_pop  = pop && vld_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
    // Valid is registered so the decoder sees a clean flag, not a compare.
    vld_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: 8'h00};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign count    = cnt_q;
  assign head_vld = vld_q;
  assign head     = vld_q ? mem_q[rd_q] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/ej32_fetch.sv
`default_nettype none
//==============================================================================
// ej32_fetch : eJ32 instruction fetch FSM, PC / fetch-address registers, prefetch
// Revision   : 1.0
//==============================================================================
module ej32_fetch
  import ej32_pkg::*;
#(
  parameter int AW    = EJ32_AW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  ej32_fetch_if.master  mem,
  input  logic          p_inc,
  input  logic          br_ld,
  input  logic [AW-1:0] br_tgt,
  input  logic          ls_bsy,
  output logic [7:0]    code,
  output logic          code_vld,
  output logic [AW-1:0] pc
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [AW-1:0] RST_PC = AW'(EJ32_RESET_VEC);

  fetch_st_t     state_q, state_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          run_q, run_d;
  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_next;

  ej32_pfq #(
    .DEPTH (DEPTH)
  ) u_pfq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem.mem_rdata),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (code),
    .head_vld  (code_vld)
  );

  always_comb begin
    state_d  = state_q;
    fa_d     = fa_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q;
    run_d    = 1'b1;
    push     = 1'b0;
    flush    = br_ld;
    pop      = p_inc && code_vld && !br_ld;
    occ_next = count + CW'(1) - CW'(pop);

    if (br_ld) begin
      fa_d = br_tgt;
      pc_d = br_tgt;
    end else if (pop) begin
      pc_d = pc_q + AW'(1);
    end

    case (state_q)
      // run_q holds off the first request for one cycle after reset release.
      F_IDLE: begin
        if (!br_ld && run_q && (count < FULL) && !ls_bsy) begin
          state_d = F_FETCH;
          req_d   = 1'b1;
          addr_d  = fa_q;
        end
      end
      F_FETCH: begin
        if (mem.mem_ack) begin
          if (br_ld) begin
            state_d = F_IDLE;
            req_d   = 1'b0;
          end else begin
            push = 1'b1;
            fa_d = fa_q + AW'(1);
            if ((occ_next < FULL) && !ls_bsy) begin
              addr_d = fa_q + AW'(1);
            end else begin
              state_d = F_IDLE;
              req_d   = 1'b0;
            end
          end
        end else if (br_ld) begin
          state_d = F_DRAIN;
        end
      end
      // Old request completes on the bus; its byte is dropped (no push here).
      F_DRAIN: begin
        if (mem.mem_ack) begin
          state_d = F_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = F_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      fa_q    <= RST_PC;
      pc_q    <= RST_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      run_q   <= run_d;
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign pc           = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ej32_fetch.sv
`default_nettype none
//==============================================================================
// tb_ej32_fetch : scoreboard bench; expected stream is program order from the
//                 last reset/redirect target, memory byte = fixed function of address
// Revision      : 1.0
//==============================================================================
module tb_ej32_fetch;
  import ej32_pkg::*;

  localparam int AW    = 17;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          p_inc  = 1'b0;
  logic          br_ld  = 1'b0;
  logic          ls_bsy = 1'b0;
  logic [AW-1:0] br_tgt = '0;
  logic [7:0]    code;
  logic          code_vld;
  logic [AW-1:0] pc;

  int n_chk = 0;
  int n_err = 0;
  int lat   = 0;
  int wcnt  = -1;

  ent_t          exp_q[$];
  logic [AW-1:0] exp_next = '0;

  logic          m_prev_req  = 1'b0;
  logic          m_prev_ack  = 1'b0;
  logic          m_prev_live = 1'b0;
  logic [AW-1:0] m_prev_addr = '0;
  int            m_stall     = 0;

  ej32_fetch_if #(.AW(AW)) mem_if ();

  ej32_fetch #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem_if),
    .p_inc    (p_inc),
    .br_ld    (br_ld),
    .br_tgt   (br_tgt),
    .ls_bsy   (ls_bsy),
    .code     (code),
    .code_vld (code_vld),
    .pc       (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return (a[7:0] + 8'h10) ^ a[15:8] ^ {7'd0, a[16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic exp_refill();
    ent_t e;
    while (exp_q.size() < 16) begin
      e.a = exp_next;
      e.d = mem_byte(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + AW'(1);
    end
  endtask

  task automatic exp_reset(input logic [AW-1:0] a);
    exp_q.delete();
    exp_next = a;
    exp_refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_br(input logic [AW-1:0] tgt);
    br_ld  = 1'b1;
    br_tgt = tgt;
    exp_reset(tgt);
  endtask

  task automatic wait_req(input string nm, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (mem_if.mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int quiet;
    quiet = 0;
    for (int i = 0; i < lim && quiet < 2; i++) begin
      tick();
      quiet = mem_if.mem_req ? 0 : quiet + 1;
    end
    chk(nm, 32'(quiet), 32'd2);
  endtask

  // Memory responder: ack after lat cycles (random 0..3 when lat < 0).
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 8'($urandom);
      if (rst || !mem_if.mem_req) begin
        wcnt = -1;
      end else begin
        if (wcnt < 0) wcnt = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
        if (wcnt == 0) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_byte(mem_if.mem_addr);
          wcnt             = -1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: compares head/pc against the expected program-order stream.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_prev_live && m_prev_req && !m_prev_ack)
          chk("req_hold", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, m_prev_addr}));
        if (!br_ld) begin
          chk("pc", 32'(pc), 32'(exp_q[0].a));
          chk("code", 32'(code), code_vld ? 32'(exp_q[0].d) : 32'd0);
          if (p_inc && code_vld) begin
            void'(exp_q.pop_front());
            exp_refill();
          end
        end
        m_stall = code_vld ? 0 : m_stall + 1;
        if (m_stall == 60) begin
          n_chk++;
          n_err++;
          $display("FAIL starve: code_vld low for %0d cycles at %0t", m_stall, $time);
        end
      end else begin
        m_stall = 0;
      end
      m_prev_live = !rst;
      m_prev_req  = mem_if.mem_req;
      m_prev_ack  = mem_if.mem_ack;
      m_prev_addr = mem_if.mem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bub;
    int   gap_req;
    bit   gap;
    bit   early;
    bit   held_bad;
    bit   quiet;
    logic [AW-1:0] old_addr;

    // Reset state
    lat = 0;
    rst = 1'b1;
    exp_reset('0);
    repeat (3) tick();
    chk("rst_req",  32'(mem_if.mem_req),  32'd0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_vld",  32'(code_vld),        32'd0);
    chk("rst_code", 32'(code),            32'd0);
    chk("rst_pc",   32'(pc),              32'd0);

    // Fill after reset: first request at r+2, addresses 0..3, then full
    rst = 1'b0;
    tick();
    chk("first_req_r1", 32'(mem_if.mem_req), 32'd0);
    tick();
    chk("first_req_r2", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, 17'h00000}));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("fill_addr", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, AW'(i)}));
    end
    tick();
    chk("full_stop", 32'(mem_if.mem_req), 32'd0);
    repeat (4) tick();
    chk("full_req",  32'(mem_if.mem_req), 32'd0);
    chk("full_vld",  32'(code_vld),       32'd1);
    chk("full_code", 32'(code),           32'h10);
    chk("full_pc",   32'(pc),             32'd0);

    // Streaming with continuous consume
    p_inc = 1'b1;
    repeat (4) tick();
    bub     = 0;
    gap_req = 0;
    for (int i = 0; i < 24; i++) begin
      if (!code_vld) bub++;
      if (!mem_if.mem_req) gap_req++;
      tick();
    end
    chk("stream_bubbles", 32'(bub),     32'd0);
    chk("stream_req_gap", 32'(gap_req), 32'd0);
    p_inc = 1'b0;

    // Redirect while a request is outstanding, ack 3 cycles later
    lat = 3;
    quiet = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_if.mem_req && !mem_if.mem_ack) begin
        quiet = 1'b1;
        break;
      end
    end
    chk("br_find_req", 32'(quiet), 32'd1);
    old_addr = mem_if.mem_addr;
    do_br(17'h00100);
    tick();
    br_ld = 1'b0;
    chk("br_flush", 32'(code_vld), 32'd0);
    chk("drain_hold", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, old_addr}));
    gap   = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      early = early | code_vld;
      if (!mem_if.mem_req) gap = 1'b1;
      if (gap && mem_if.mem_req) break;
    end
    chk("br_gap_then_req", 32'({gap, mem_if.mem_req}), 32'b11);
    chk("br_new_addr",     32'(mem_if.mem_addr),       32'h00100);
    chk("br_no_stale",     32'(early),                 32'd0);
    lat = 0;

    // ls_bsy blocks new requests, holds none, and fetch resumes at fa
    wait_idle("idle_before_ls", 40);
    ls_bsy = 1'b1;
    do_br(17'h00200);
    tick();
    br_ld = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 6; i++) begin
      quiet = quiet | mem_if.mem_req;
      tick();
    end
    chk("lsbsy_block", 32'(quiet), 32'd0);
    lat    = 3;
    ls_bsy = 1'b0;
    wait_req("lsbsy_wait", 4);
    chk("lsbsy_resume", 32'(mem_if.mem_addr), 32'h00200);
    ls_bsy   = 1'b1;
    held_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_if.mem_ack) break;
      if (!(mem_if.mem_req && mem_if.mem_addr == 17'h00200)) held_bad = 1'b1;
    end
    chk("lsbsy_ack_seen", 32'(mem_if.mem_ack), 32'd1);
    chk("lsbsy_held",     32'(held_bad),       32'd0);
    tick();
    chk("lsbsy_stop", 32'(mem_if.mem_req), 32'd0);
    ls_bsy = 1'b0;
    lat    = 0;
    wait_req("lsbsy_wait2", 4);
    chk("lsbsy_fa", 32'(mem_if.mem_addr), 32'h00201);

    // Simultaneous br_ld, p_inc and mem_ack
    quiet = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_if.mem_ack && code_vld) begin
        quiet = 1'b1;
        break;
      end
      tick();
    end
    chk("sim_find", 32'(quiet), 32'd1);
    do_br(17'h0A5A0);
    p_inc = 1'b1;
    tick();
    br_ld = 1'b0;
    p_inc = 1'b0;
    chk("sim_flush", 32'(code_vld), 32'd0);
    chk("sim_pc",    32'(pc),       32'h0A5A0);
    wait_req("sim_wait", 4);
    chk("sim_next",  32'(mem_if.mem_addr), 32'h0A5A0);

    // Redirect latency from idle and address wrap
    wait_idle("idle_before_wrap", 40);
    do_br(17'h1FFFF);
    tick();
    br_ld = 1'b0;
    chk("redir_t1", 32'(mem_if.mem_req), 32'd0);
    tick();
    chk("redir_t2", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, 17'h1FFFF}));
    tick();
    chk("redir_t3_vld",  32'(code_vld), 32'd1);
    chk("redir_t3_code", 32'(code),     32'(mem_byte(17'h1FFFF)));
    chk("wrap_next", 32'({mem_if.mem_req, mem_if.mem_addr}), 32'({1'b1, 17'h00000}));

    // Randomized traffic
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        rst   = 1'b1;
        p_inc = 1'b0;
        br_ld = 1'b0;
        exp_reset('0);
        tick();
        tick();
        rst = 1'b0;
      end
      p_inc  = ($urandom_range(9, 0) < 7);
      ls_bsy = ($urandom_range(7, 0) == 0);
      br_ld  = 1'b0;
      if ($urandom_range(31, 0) == 0) begin
        if ($urandom_range(3, 0) == 0) do_br(17'h1FFFC + AW'($urandom_range(3, 0)));
        else                           do_br(AW'($urandom));
      end
      tick();
    end
    p_inc  = 1'b0;
    br_ld  = 1'b0;
    ls_bsy = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ej32_fetch.md
# ej32_fetch

Instruction fetch and prefetch unit for the eJ32 core. It owns the program counter and issues byte-wide reads on the shared memory bus. Fetched bytecode is buffered in a small queue, and the head byte drives the decoder's `data` input. Each decoder `p_inc` consumes one byte. The unit accepts branch redirects from BR and defers new requests while LS owns the bus.

## Interface
Parameters:
- `AW`, 17, byte address width (PC, memory address).
- `DEPTH`, 4, prefetch queue entries; power of 2, ≥2.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `p_inc`  in  1  decoder consumes head byte this cycle.
- `br_ld`  in  1  branch/redirect strobe from BR.
- `br_tgt`  in  AW  redirect target address, valid with `br_ld`.
- `ls_bsy`  in  1  LS unit owns the memory bus; no new request may start.
- `mem_req`  out  1  fetch read request.
- `mem_addr`  out  AW  fetch byte address.
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle.
- `mem_rdata`  in  8  returned byte.
- `code`  out  8  head byte to decoder; 8'h00 when `code_vld`=0.
- `code_vld`  out  1  queue non-empty.
- `pc`  out  AW  address of head byte.

## Operation
- State machine (`fetch_st_t`) has three states: F_IDLE, F_FETCH and F_DRAIN.
- F_IDLE → F_FETCH when `count` < DEPTH and `ls_bsy`=0. `mem_addr` is taken from `fa`, the next-fetch address.
- F_FETCH holds `mem_req`=1 with `mem_addr` stable until `mem_ack`. A started request is never abandoned, and `ls_bsy` does not affect it.
- On ack in F_FETCH, push `mem_rdata` and increment `fa`. Then:
  - Stay in F_FETCH with the new address next cycle if the post-push occupancy is < DEPTH and `ls_bsy`=0.
  - Otherwise go to F_IDLE.
- `br_ld` arriving in F_IDLE, or in F_FETCH together with `mem_ack`:
  - flush the queue (count=0);
  - set `fa`=`br_tgt` and `pc`=`br_tgt`;
  - discard any byte acked that cycle;
  - go to F_IDLE. F_FETCH can start on the following cycle.
- `br_ld` in F_FETCH without ack:
  - flush the queue;
  - latch `br_tgt` into both `fa` and `pc`;
  - go to F_DRAIN.
- F_DRAIN keeps `mem_req`=1 at the old address until ack, discards the data, then goes to F_IDLE.
- `br_ld` in F_DRAIN re-latches the target and stays in F_DRAIN.
- Pop: `p_inc`=1 and `code_vld`=1 advance the read pointer and `pc`+1. `p_inc` while empty is ignored.
- Push and pop in the same cycle leave `count` unchanged.
- `br_ld` has priority over both `p_inc` and push in the same cycle.
- Arithmetic and widths:
  - `fa` and `pc` wrap modulo 2^AW.
  - Queue pointers are log2(DEPTH) bits and wrap naturally.
  - `count` is log2(DEPTH)+1 bits and never exceeds DEPTH.
- At most one request is outstanding at any time.

## Timing
- Reset values: state=F_IDLE; count=0; `fa`=0; `pc`=0; `mem_req`=0; `mem_addr`=0; `code_vld`=0; `code`=8'h00.
- `rst` asserted mid-request drops the request with no drain; the memory side must tolerate this.
- First request after reset is at cycle r+2, where cycle r is the one in which `rst` is sampled low; `mem_addr`=0.
- All state is registered. A byte acked at cycle t appears on `code` with `code_vld`=1 at t+1. There is no bypass.
- Redirect latency (F_IDLE, bus free): `br_ld` at t → `mem_req`/`mem_addr`=`br_tgt` at t+2 → with immediate ack, `code_vld` at t+3.
- Streaming throughput: one byte per cycle under continuous ack.
- Queue full (count=DEPTH): no request is issued, and `code` holds.
- `mem_req`, `mem_addr` and `code_vld` are registered outputs. `code` is a mux of queue storage by the registered read pointer.

## Structure
- `ej32_pkg` gets:
  - `fetch_st_t` enum {F_IDLE, F_FETCH, F_DRAIN};
  - the default address width constant;
  - the reset vector constant, 0.
- Sub-module `ej32_pfq` is the synchronous DEPTH×8 queue with push, pop, flush, count, and head output.
- `ej32_fetch` contains the FSM plus the `fa` and `pc` registers.

## Test plan
- Reset, then memory returns 8'h10,8'h11,… with ack every cycle and `p_inc`=0 → requests at addr 0..3; then `mem_req`=0; count=4; `code`=8'h10; `pc`=0.
- Continuous `p_inc`=1 with ack every cycle → `code` sequence 8'h10,8'h11,… with no bubbles after fill; `pc` increments by 1 per cycle.
- `br_ld` with `br_tgt`=17'h00100 while a request is outstanding, ack 3 cycles later → that byte is discarded; next request is at 0x100; `pc`=0x100; `code_vld`=0 until the 0x100 byte arrives.
- `ls_bsy`=1 while count<DEPTH → no new `mem_req`. Assert `ls_bsy` during an outstanding request → request held to ack. Release → fetch resumes at the correct `fa`.
- Simultaneous `br_ld`, `p_inc` and `mem_ack` → queue empty; `pc`=`br_tgt`; acked byte dropped.
- Wrap: `br_tgt`=17'h1FFFF → requests 0x1FFFF then 0x00000.
